// File: rtl/sw_debounce.sv
// Switch/button debouncer: 2-flop synchronizer, shared sample prescaler, and one
// saturating-free 3-bit stability counter per input lane, with registered strobes.
module sw_debounce_lane #(
  parameter int STABLE_CNT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic smp,
  output logic level,
  output logic flip
);
  logic [2:0] cnt;
  logic       diff;

  assign diff = smp ^ level;
  assign flip = tick & diff & (cnt == 3'(STABLE_CNT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (tick) begin
      if (!diff) begin
        cnt <= '0;
      end else if (flip) begin
        level <= ~level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 3'd1;
      end
    end
  end
endmodule

module sw_debounce #(
  parameter int TICK_W     = 17,
  parameter int STABLE_CNT = 4
) (
  input  logic        clk_dis,
  input  logic        rst,
  input  logic [15:0] sw_in,
  input  logic [4:0]  btn_in,
  output logic [15:0] sw_out,
  output logic        sw_changed,
  output logic [4:0]  btn_level,
  output logic [4:0]  btn_pulse
);
  localparam int NUM_LANES = 21;

  logic [1:0][NUM_LANES-1:0] sync_pipe;
  logic [TICK_W-1:0]         pre;
  logic                      tick;
  logic [NUM_LANES-1:0]      level;
  logic [NUM_LANES-1:0]      flip;

  always_ff @(posedge clk_dis) begin
    if (rst) begin
      sync_pipe <= '0;
      pre       <= '0;
    end else begin
      sync_pipe <= {sync_pipe[0], {btn_in, sw_in}};
      pre       <= pre + 1'b1;
    end
  end

  assign tick = &pre;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    sw_debounce_lane #(.STABLE_CNT(STABLE_CNT)) u_lane (
      .clk  (clk_dis),
      .rst  (rst),
      .tick (tick),
      .smp  (sync_pipe[1][i]),
      .level(level[i]),
      .flip (flip[i])
    );
  end

  // Strobes are registered from the flip terms so they line up with the new level.
  always_ff @(posedge clk_dis) begin
    if (rst) begin
      sw_changed <= 1'b0;
      btn_pulse  <= '0;
    end else begin
      sw_changed <= |flip[15:0];
      btn_pulse  <= flip[20:16] & ~level[20:16];
    end
  end

  assign sw_out    = level[15:0];
  assign btn_level = level[20:16];
endmodule

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce with TICK_W=2 (P=4) and STABLE_CNT=3.
module tb_sw_debounce;
  logic        clk_dis = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] sw_in = 16'hFFFF;
  logic [4:0]  btn_in = '0;
  logic [15:0] sw_out;
  logic        sw_changed;
  logic [4:0]  btn_level;
  logic [4:0]  btn_pulse;

  int checks = 0, errors = 0;
  int chg_cnt = 0, upd_cnt = 0;
  int pcnt [5];
  logic        rst_q = 1'b1;
  logic [15:0] sw_prev = '0;
  logic [4:0]  btn_prev = '0;

  sw_debounce #(.TICK_W(2), .STABLE_CNT(3)) dut (
    .clk_dis   (clk_dis),
    .rst       (rst),
    .sw_in     (sw_in),
    .btn_in    (btn_in),
    .sw_out    (sw_out),
    .sw_changed(sw_changed),
    .btn_level (btn_level),
    .btn_pulse (btn_pulse)
  );

  always #5 clk_dis = ~clk_dis;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk_dis) rst_q <= rst;

  // Strobes must coincide with the first cycle of each output transition.
  always @(negedge clk_dis) begin
    if (!rst_q) begin
      chk("chg_sync", {31'd0, sw_changed}, {31'd0, sw_out != sw_prev});
      chk("pulse_sync", {27'd0, btn_pulse}, {27'd0, btn_level & ~btn_prev});
    end
    if (sw_changed) chg_cnt++;
    if (sw_out != sw_prev) upd_cnt++;
    for (int i = 0; i < 5; i++) if (btn_pulse[i]) pcnt[i]++;
    sw_prev  = sw_out;
    btn_prev = btn_level;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_dis);
  endtask

  task automatic clr_cnt();
    chg_cnt = 0;
    upd_cnt = 0;
    for (int i = 0; i < 5; i++) pcnt[i] = 0;
  endtask

  task automatic wait_sw(input logic [15:0] val, output int n);
    n = 0;
    while (sw_out !== val && n < 30) begin
      @(negedge clk_dis);
      n++;
    end
  endtask

  task automatic wait_btn(input int b, input logic val, output int n);
    n = 0;
    while (btn_level[b] !== val && n < 30) begin
      @(negedge clk_dis);
      n++;
    end
  endtask

  initial begin
    int  n;
    logic saw;
    for (int i = 0; i < 5; i++) pcnt[i] = 0;

    // Reset with switches high: outputs stay 0 throughout.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_dis);
      chk("rst_sw", {16'd0, sw_out}, 32'd0);
      chk("rst_misc", {26'd0, sw_changed, btn_level}, 32'd0);
      chk("rst_pulse", {27'd0, btn_pulse}, 32'd0);
    end
    clr_cnt();
    rst = 1'b0;
    wait_sw(16'hFFFF, n);
    chk("rst_rel_val", {16'd0, sw_out}, 32'h0000FFFF);
    chk("rst_rel_lat", {31'd0, n >= 10 && n <= 15}, 32'd1);
    cyc(6);
    chk("rst_rel_chg", chg_cnt, 32'd1);

    // Clean single-bit edge.
    sw_in = 16'h0000;
    wait_sw(16'h0000, n);
    chk("clr_val", {16'd0, sw_out}, 32'd0);
    cyc(3);
    clr_cnt();
    sw_in = 16'h8000;
    wait_sw(16'h8000, n);
    chk("edge_val", {16'd0, sw_out}, 32'h00008000);
    chk("edge_lat", {31'd0, n >= 10 && n <= 15}, 32'd1);
    cyc(6);
    chk("edge_hold", {16'd0, sw_out}, 32'h00008000);
    chk("edge_chg", chg_cnt, 32'd1);

    // Bounce on btn 0: 3-cycle halves never give 3 agreeing P=4 samples.
    clr_cnt();
    saw = 1'b0;
    for (int t = 0; t < 10; t++) begin
      btn_in[0] = ~btn_in[0];
      for (int k = 0; k < 3; k++) begin
        @(negedge clk_dis);
        saw |= btn_level[0];
      end
    end
    chk("bounce_quiet", {31'd0, saw}, 32'd0);
    btn_in[0] = 1'b1;
    wait_btn(0, 1'b1, n);
    chk("bounce_rise", {31'd0, btn_level[0]}, 32'd1);
    chk("bounce_lat", {31'd0, n <= 15}, 32'd1);
    cyc(8);
    chk("bounce_pcnt", pcnt[0], 32'd1);

    // Release of btn 2 gives a level fall and no pulse.
    btn_in[2] = 1'b1;
    wait_btn(2, 1'b1, n);
    chk("rel_accept", {31'd0, btn_level[2]}, 32'd1);
    cyc(2);
    clr_cnt();
    btn_in[2] = 1'b0;
    wait_btn(2, 1'b0, n);
    chk("rel_fall", {31'd0, btn_level[2]}, 32'd0);
    chk("rel_lat", {31'd0, n <= 15}, 32'd1);
    cyc(6);
    chk("rel_pcnt", pcnt[2], 32'd0);
    chk("rel_lvl", {27'd0, btn_level}, 32'h00000001);

    // Several bits flipping together.
    sw_in = 16'h0000;
    wait_sw(16'h0000, n);
    cyc(3);
    clr_cnt();
    sw_in = 16'h8421;
    wait_sw(16'h8421, n);
    chk("multi_val", {16'd0, sw_out}, 32'h00008421);
    cyc(6);
    chk("multi_upd", upd_cnt, 32'd1);
    chk("multi_chg", chg_cnt, 32'd1);

    // Reset in the middle of a debounce interval.
    sw_in = 16'h0000;
    wait_sw(16'h0000, n);
    cyc(3);
    sw_in = 16'h0008;
    cyc(6);
    chk("mid_pre", {16'd0, sw_out}, 32'd0);
    rst = 1'b1;
    @(negedge clk_dis);
    chk("mid_rst_sw", {16'd0, sw_out}, 32'd0);
    chk("mid_rst_btn", {27'd0, btn_level}, 32'd0);
    rst = 1'b0;
    wait_sw(16'h0008, n);
    chk("mid_val", {16'd0, sw_out}, 32'h00000008);
    chk("mid_lat", {31'd0, n >= 10 && n <= 15}, 32'd1);

    cyc(4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sw_debounce.md
SW_DEBOUNCE -- requirements
Module: sw_debounce

Interface
REQ-001 SHALL have parameter TICK_W, default 17, giving the sample period P = 2^TICK_W clk_dis cycles (about 1.31 ms at 100 MHz).
REQ-002 SHALL have parameter STABLE_CNT, default 4, the number of consecutive differing samples needed to accept a new level; legal range 1..7.
REQ-003 SHALL have port clk_dis, input, 1 bit: the single board clock; every flop is clocked on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: the reset, which is synchronous and active-high.
REQ-005 SHALL have port sw_in, input, 16 bits: raw asynchronous slide switches.
REQ-006 SHALL have port btn_in, input, 5 bits: raw asynchronous push buttons.
REQ-007 SHALL have port sw_out, output, 16 bits: debounced switch levels, feeding the clock-divider speed select and CPU display select.
REQ-008 SHALL have port sw_changed, output, 1 bit: a one-cycle strobe when any sw_out bit flips.
REQ-009 SHALL have port btn_level, output, 5 bits: debounced button levels.
REQ-010 SHALL have port btn_pulse, output, 5 bits: a one-cycle press strobe per button (for single-step and similar uses).

Function
REQ-011 SHALL pass all 21 raw inputs through a 2-flop synchronizer before any other use.
REQ-012 SHALL run a free-running TICK_W-bit prescaler; tick is high for exactly one cycle when the prescaler is all-ones, and the prescaler then wraps to 0.
REQ-013 SHALL keep one 3-bit counter per input; counters change only on tick cycles.
REQ-014 SHALL clear an input's counter on a tick when the synchronized bit equals its debounced output.
REQ-015 SHALL increment an input's counter on a tick when the synchronized bit differs from its debounced output.
REQ-016 SHALL, on the tick where a differing sample makes the count reach STABLE_CNT, invert the debounced output and clear the counter in the same edge.
REQ-017 SHALL make a new stable input level appear on the output no earlier than (STABLE_CNT-1)*P+2 and no later than STABLE_CNT*P+3 cycles after the raw input edge.
REQ-018 SHALL suppress any glitch or bounce that does not persist through STABLE_CNT consecutive ticks; the output does not change.
REQ-019 SHALL update independent bits independently; several bits may flip on the same tick.
REQ-020 SHALL assert sw_changed for exactly one cycle, registered and coincident with the first cycle the new sw_out value is visible, regardless of how many bits flipped.
REQ-021 SHALL assert btn_pulse[i] for exactly one cycle, coincident with btn_level[i] going 0->1.
REQ-022 SHALL produce no btn_pulse[i] on a 1->0 release of btn_level[i].
REQ-023 SHALL keep the output stable while an input is held steady indefinitely; counters do not overflow because a counter is cleared whenever input equals output.
REQ-024 SHALL drive every output from a register, with no combinational path from any input to any output.

Reset
REQ-025 SHALL, when rst is high on a clk_dis edge, clear the synchronizers, prescaler, all counters, sw_out, btn_level, sw_changed and btn_pulse to 0.
REQ-026 SHALL apply reset mid-debounce: a partially accumulated count is discarded and outputs return to 0 on that edge.
REQ-027 SHALL NOT preload outputs from inputs; inputs high during reset reach the outputs only after a full debounce interval from reset release, and that transition produces the normal sw_changed or btn_pulse strobe.

Verification (TICK_W=2, P=4, STABLE_CNT=3)
REQ-028 SHALL be checked for reset: hold rst 3 cycles with sw_in=16'hFFFF -> all outputs 0 during reset; sw_out=16'hFFFF within 15 cycles of release, sw_changed high exactly 1 cycle.
REQ-029 SHALL be checked for a clean edge: sw_in[15] 0->1 and held -> sw_out[15]=1 no earlier than 10 and no later than 15 cycles after the edge, one sw_changed pulse, other bits unchanged.
REQ-030 SHALL be checked for bounce: btn_in[0] toggling every 3 cycles for 30 cycles, then held 1 -> btn_level[0] stays 0 while toggling, then rises once, btn_pulse[0] high exactly 1 cycle, total pulse count 1.
REQ-031 SHALL be checked for release: btn_in[2] 1->0 after being accepted -> btn_level[2] falls within 15 cycles, btn_pulse[2] never asserted.
REQ-032 SHALL be checked for simultaneous changes: sw_in 16'h0000->16'h8421 in one cycle -> sw_out=16'h8421 in a single update, sw_changed exactly 1 cycle.
REQ-033 SHALL be checked for mid-operation reset: sw_in[3] raised, rst pulsed 1 cycle 6 cycles later -> sw_out[3] stays 0 until a full new interval (no earlier than 10 cycles after rst release).
